// File: rtl/alu_hazard_scheduler.sv
// alu_hazard_scheduler
// Issue controller sitting in front of the ALU stage. It remembers the destination
// registers of the instructions in the EX and MEM slots, decides each cycle whether
// decode may issue, selects operand forwarding sources, inserts a single bubble on a
// load-use dependency and counts those stall cycles (saturating) for performance debug.
module alu_hazard_scheduler #(
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_valid,
  input  logic [ADDR_W-1:0]      src1_addr,
  input  logic                   src1_used,
  input  logic [ADDR_W-1:0]      src2_addr,
  input  logic                   src2_used,
  input  logic [ADDR_W-1:0]      dst_addr,
  input  logic                   write_back,
  input  logic                   mem_read,
  input  logic                   hold,
  input  logic                   flush,
  output logic                   issue_fire,
  output logic                   stall,
  output logic [1:0]             fwd_sel1,
  output logic [1:0]             fwd_sel2,
  output logic [(1<<ADDR_W)-1:0] busy_mask,
  output logic [CNT_W-1:0]       stall_count
);

  localparam int NREG = 1 << ADDR_W;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  // EX slot: the instruction issued last cycle
  logic              ex_v;
  logic [ADDR_W-1:0] ex_dst;
  logic              ex_wb;
  logic              ex_ld;

  // MEM slot: the instruction issued two cycles ago
  logic              mem_v;
  logic [ADDR_W-1:0] mem_dst;
  logic              mem_wb;

  logic ex_hit1;
  logic ex_hit2;
  logic mem_hit1;
  logic mem_hit2;

  // Dependency detection: a slot hits an operand when it holds a live writer of that register
  always_comb begin
    ex_hit1  = ex_v  && ex_wb  && (ex_dst  == src1_addr) && src1_used;
    ex_hit2  = ex_v  && ex_wb  && (ex_dst  == src2_addr) && src2_used;
    mem_hit1 = mem_v && mem_wb && (mem_dst == src1_addr) && src1_used;
    mem_hit2 = mem_v && mem_wb && (mem_dst == src2_addr) && src2_used;
  end

  // Load-use stall and issue acceptance; both forced low while reset is asserted
  always_comb begin
    stall      = rst_n && ex_ld && (ex_hit1 || ex_hit2);
    issue_fire = rst_n && issue_valid && !stall && !hold && !flush;
  end

  // Forwarding selects: the younger EX result wins over MEM; a load in EX cannot forward
  always_comb begin
    fwd_sel1 = SEL_RF;
    fwd_sel2 = SEL_RF;
    if (ex_hit1 && !ex_ld) begin
      fwd_sel1 = SEL_EX;
    end else if (mem_hit1) begin
      fwd_sel1 = SEL_MEM;
    end
    if (ex_hit2 && !ex_ld) begin
      fwd_sel2 = SEL_EX;
    end else if (mem_hit2) begin
      fwd_sel2 = SEL_MEM;
    end
  end

  // Busy mask decoded purely from the registered slots
  always_comb begin
    busy_mask = '0;
    for (int r = 0; r < NREG; r++) begin
      busy_mask[r] = (ex_v  && ex_wb  && (ex_dst  == ADDR_W'(r))) ||
                     (mem_v && mem_wb && (mem_dst == ADDR_W'(r)));
    end
  end

  // Slot pipeline: advance EX into MEM and refill EX, or freeze on hold
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_v    <= 1'b0;
      ex_dst  <= '0;
      ex_wb   <= 1'b0;
      ex_ld   <= 1'b0;
      mem_v   <= 1'b0;
      mem_dst <= '0;
      mem_wb  <= 1'b0;
    end else if (hold) begin
      if (flush) begin
        ex_v <= 1'b0;
      end
    end else begin
      mem_v   <= ex_v && !flush;
      mem_dst <= ex_dst;
      mem_wb  <= ex_wb;
      ex_v    <= issue_fire;
      ex_dst  <= dst_addr;
      ex_wb   <= write_back;
      ex_ld   <= mem_read && write_back;
    end
  end

  // Saturating count of load-use stall cycles that actually cost a slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall && !hold && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_hazard_scheduler.sv
// tb_alu_hazard_scheduler
// Directed bench for alu_hazard_scheduler. A second instance with a 4-bit counter
// shares every input so counter saturation can be observed in a short run.
module tb_alu_hazard_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       issue_valid;
  logic [2:0] src1_addr;
  logic       src1_used;
  logic [2:0] src2_addr;
  logic       src2_used;
  logic [2:0] dst_addr;
  logic       write_back;
  logic       mem_read;
  logic       hold;
  logic       flush;

  logic        issue_fire;
  logic        stall;
  logic [1:0]  fwd_sel1;
  logic [1:0]  fwd_sel2;
  logic [7:0]  busy_mask;
  logic [15:0] stall_count;

  logic        issue_fire4;
  logic        stall4;
  logic [1:0]  fwd_sel1_4;
  logic [1:0]  fwd_sel2_4;
  logic [7:0]  busy_mask4;
  logic [3:0]  stall_count4;

  int n_vec = 0;
  int n_err = 0;
  int exp_count = 0;

  alu_hazard_scheduler #(.ADDR_W(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid),
    .src1_addr(src1_addr), .src1_used(src1_used),
    .src2_addr(src2_addr), .src2_used(src2_used),
    .dst_addr(dst_addr), .write_back(write_back), .mem_read(mem_read),
    .hold(hold), .flush(flush),
    .issue_fire(issue_fire), .stall(stall),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .busy_mask(busy_mask), .stall_count(stall_count)
  );

  alu_hazard_scheduler #(.ADDR_W(3), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid),
    .src1_addr(src1_addr), .src1_used(src1_used),
    .src2_addr(src2_addr), .src2_used(src2_used),
    .dst_addr(dst_addr), .write_back(write_back), .mem_read(mem_read),
    .hold(hold), .flush(flush),
    .issue_fire(issue_fire4), .stall(stall4),
    .fwd_sel1(fwd_sel1_4), .fwd_sel2(fwd_sel2_4),
    .busy_mask(busy_mask4), .stall_count(stall_count4)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  // Advance past the next rising edge and let registered outputs settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Quiet inputs: nothing issued, no operands read
  task automatic idle();
    issue_valid = 1'b0;
    src1_addr = 3'd0; src1_used = 1'b0;
    src2_addr = 3'd0; src2_used = 1'b0;
    dst_addr = 3'd0; write_back = 1'b0; mem_read = 1'b0;
    hold = 1'b0; flush = 1'b0;
  endtask

  // Present one instruction (sources unused unless set afterwards)
  task automatic present(input logic [2:0] dst, input logic wb, input logic ld);
    idle();
    issue_valid = 1'b1;
    dst_addr = dst; write_back = wb; mem_read = ld;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    present(3'd1, 1'b1, 1'b0);
    src1_addr = 3'd1; src1_used = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if (issue_fire !== 1'b0) begin n_err++; $display("[TB] FAIL reset_fire cyc%0d: got %b want 0", i, issue_fire); end
      n_vec++;
      if (stall !== 1'b0) begin n_err++; $display("[TB] FAIL reset_stall cyc%0d: got %b want 0", i, stall); end
      step();
    end
    rst_n = 1'b1;
    idle();
    #1;
    exp_count = 0;
    n_vec++;
    if (busy_mask !== 8'h00) begin n_err++; $display("[TB] FAIL reset_busy: got %h want 00", busy_mask); end
    n_vec++;
    if (stall_count !== 16'd0) begin n_err++; $display("[TB] FAIL reset_count: got %0d want 0", stall_count); end
    n_vec++;
    if (stall !== 1'b0 || fwd_sel1 !== 2'b00 || fwd_sel2 !== 2'b00) begin
      n_err++; $display("[TB] FAIL reset_outs: stall %b fwd1 %b fwd2 %b want 0 00 00", stall, fwd_sel1, fwd_sel2);
    end
  endtask

  task automatic test_alu_chain();
    present(3'd3, 1'b1, 1'b0);
    #1;
    n_vec++;
    if (issue_fire !== 1'b1) begin n_err++; $display("[TB] FAIL chain_fire0: got %b want 1", issue_fire); end
    step();
    present(3'd4, 1'b1, 1'b0);
    src1_addr = 3'd3; src1_used = 1'b1;
    #1;
    n_vec++;
    if (fwd_sel1 !== 2'b01) begin n_err++; $display("[TB] FAIL chain_fwd1_ex: got %b want 01", fwd_sel1); end
    n_vec++;
    if (stall !== 1'b0 || issue_fire !== 1'b1) begin n_err++; $display("[TB] FAIL chain_issue1: stall %b fire %b want 0 1", stall, issue_fire); end
    n_vec++;
    if (busy_mask !== 8'h08) begin n_err++; $display("[TB] FAIL chain_busy1: got %h want 08", busy_mask); end
    step();
    present(3'd6, 1'b0, 1'b0);
    src2_addr = 3'd3; src2_used = 1'b1;
    #1;
    n_vec++;
    if (fwd_sel2 !== 2'b10 || fwd_sel1 !== 2'b00) begin n_err++; $display("[TB] FAIL chain_fwd2_mem: fwd2 %b fwd1 %b want 10 00", fwd_sel2, fwd_sel1); end
    n_vec++;
    if (busy_mask !== 8'h18) begin n_err++; $display("[TB] FAIL chain_busy2: got %h want 18", busy_mask); end
    step();
    idle();
    #1;
    n_vec++;
    if (busy_mask !== 8'h10) begin n_err++; $display("[TB] FAIL chain_busy_nowb: got %h want 10", busy_mask); end
    step();
    step();
  endtask

  task automatic test_load_use();
    present(3'd5, 1'b1, 1'b1);
    step();
    present(3'd1, 1'b1, 1'b0);
    src1_addr = 3'd5; src1_used = 1'b1;
    #1;
    n_vec++;
    if (stall !== 1'b1 || issue_fire !== 1'b0) begin n_err++; $display("[TB] FAIL lu_stall: stall %b fire %b want 1 0", stall, issue_fire); end
    n_vec++;
    if (busy_mask !== 8'h20) begin n_err++; $display("[TB] FAIL lu_busy: got %h want 20", busy_mask); end
    step();
    exp_count++;
    n_vec++;
    if (stall_count !== 16'(exp_count)) begin n_err++; $display("[TB] FAIL lu_count: got %0d want %0d", stall_count, exp_count); end
    n_vec++;
    if (stall !== 1'b0 || fwd_sel1 !== 2'b10 || issue_fire !== 1'b1) begin
      n_err++; $display("[TB] FAIL lu_resume: stall %b fwd1 %b fire %b want 0 10 1", stall, fwd_sel1, issue_fire);
    end
    step();
    idle();
    step();
    step();
  endtask

  task automatic test_no_writeback();
    present(3'd7, 1'b0, 1'b1);
    step();
    idle();
    src1_addr = 3'd7; src1_used = 1'b1;
    #1;
    n_vec++;
    if (stall !== 1'b0 || fwd_sel1 !== 2'b00 || busy_mask !== 8'h00) begin
      n_err++; $display("[TB] FAIL nowb_load: stall %b fwd1 %b busy %h want 0 00 00", stall, fwd_sel1, busy_mask);
    end
    step();
    step();
  endtask

  task automatic test_priority();
    present(3'd2, 1'b1, 1'b0);
    step();
    present(3'd2, 1'b1, 1'b0);
    step();
    idle();
    src1_addr = 3'd2; src1_used = 1'b1;
    src2_addr = 3'd2; src2_used = 1'b1;
    #1;
    n_vec++;
    if (fwd_sel1 !== 2'b01 || fwd_sel2 !== 2'b01) begin n_err++; $display("[TB] FAIL prio_ex: fwd1 %b fwd2 %b want 01 01", fwd_sel1, fwd_sel2); end
    src1_used = 1'b0; src2_used = 1'b0;
    #1;
    n_vec++;
    if (fwd_sel1 !== 2'b00 || fwd_sel2 !== 2'b00) begin n_err++; $display("[TB] FAIL prio_unused: fwd1 %b fwd2 %b want 00 00", fwd_sel1, fwd_sel2); end
    step();
    step();
  endtask

  task automatic test_flush();
    present(3'd5, 1'b1, 1'b1);
    step();
    present(3'd1, 1'b1, 1'b0);
    src1_addr = 3'd5; src1_used = 1'b1;
    flush = 1'b1;
    #1;
    n_vec++;
    if (issue_fire !== 1'b0 || stall !== 1'b1) begin n_err++; $display("[TB] FAIL flush_cycle: fire %b stall %b want 0 1", issue_fire, stall); end
    step();
    exp_count++;
    flush = 1'b0;
    #1;
    n_vec++;
    if (busy_mask[5] !== 1'b0 || stall !== 1'b0) begin n_err++; $display("[TB] FAIL flush_after: busy5 %b stall %b want 0 0", busy_mask[5], stall); end
    n_vec++;
    if (fwd_sel1 !== 2'b00 || stall_count !== 16'(exp_count)) begin
      n_err++; $display("[TB] FAIL flush_state: fwd1 %b count %0d want 00 %0d", fwd_sel1, stall_count, exp_count);
    end
    idle();
    step();
    step();
  endtask

  task automatic test_hold();
    present(3'd5, 1'b1, 1'b1);
    step();
    present(3'd1, 1'b1, 1'b0);
    src1_addr = 3'd5; src1_used = 1'b1;
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++;
      if (busy_mask !== 8'h20 || stall_count !== 16'(exp_count)) begin
        n_err++; $display("[TB] FAIL hold_frozen cyc%0d: busy %h count %0d want 20 %0d", i, busy_mask, stall_count, exp_count);
      end
      n_vec++;
      if (issue_fire !== 1'b0 || stall !== 1'b1) begin n_err++; $display("[TB] FAIL hold_outs cyc%0d: fire %b stall %b want 0 1", i, issue_fire, stall); end
      step();
    end
    hold = 1'b0;
    step();
    exp_count++;
    n_vec++;
    if (stall_count !== 16'(exp_count) || fwd_sel1 !== 2'b10 || issue_fire !== 1'b1) begin
      n_err++; $display("[TB] FAIL hold_release: count %0d fwd1 %b fire %b want %0d 10 1", stall_count, fwd_sel1, issue_fire, exp_count);
    end
    idle();
    step();
    step();
  endtask

  task automatic test_saturation();
    logic exp_stall;
    present(3'd5, 1'b1, 1'b1);
    step();
    for (int i = 0; i < 40; i++) begin
      present(3'd5, 1'b1, 1'b1);
      src1_addr = 3'd5; src1_used = 1'b1;
      exp_stall = (i % 2 == 0);
      #1;
      n_vec++;
      if (stall !== exp_stall || issue_fire !== !exp_stall) begin
        n_err++; $display("[TB] FAIL sat_pattern cyc%0d: stall %b fire %b want %b %b", i, stall, issue_fire, exp_stall, !exp_stall);
      end
      step();
      if (exp_stall) exp_count++;
    end
    idle();
    #1;
    n_vec++;
    if (stall_count4 !== 4'hF) begin n_err++; $display("[TB] FAIL sat_cnt4: got %0d want 15", stall_count4); end
    n_vec++;
    if (stall_count !== 16'(exp_count)) begin n_err++; $display("[TB] FAIL sat_cnt16: got %0d want %0d", stall_count, exp_count); end
    step();
    step();
  endtask

  task automatic test_reset_mid_stall();
    present(3'd5, 1'b1, 1'b1);
    step();
    present(3'd1, 1'b1, 1'b0);
    src1_addr = 3'd5; src1_used = 1'b1;
    #1;
    n_vec++;
    if (stall !== 1'b1) begin n_err++; $display("[TB] FAIL midrst_pre: stall %b want 1", stall); end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (stall !== 1'b0 || issue_fire !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_comb: stall %b fire %b want 0 0", stall, issue_fire); end
    step();
    exp_count = 0;
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (busy_mask !== 8'h00 || stall !== 1'b0 || stall_count !== 16'(exp_count) || stall_count4 !== 4'd0) begin
      n_err++; $display("[TB] FAIL midrst_after: busy %h stall %b count %0d cnt4 %0d want 00 0 0 0", busy_mask, stall, stall_count, stall_count4);
    end
    idle();
    step();
  endtask

  // Scenario sequence
  initial begin
    rst_n = 1'b0;
    idle();
    #2;
    test_reset();
    test_alu_chain();
    test_load_use();
    test_no_writeback();
    test_priority();
    test_flush();
    test_hold();
    test_saturation();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
